matrix_result_sink: RTL and testbench
=====================================

Name: matrix_result_sink

Overview:
- Downstream consumer of the matrix master's M1 bus: captures the result words the master writes out after a multiply and stores them in an 8-deep result buffer.
- Tracks which result slots have arrived. Raises a level done flag and a one-cycle interrupt pulse once the full result set is collected.
- Exposes results and status to the host through a simple slave read/write port.

Parameters:
- BASE_ADDR, 8'h20, first M1 address of the result window
- NUM_RESULTS, 8, result words per operation (1..8; slot index is 3 bits)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- M1_req  input  1  master bus request, qualifies the M1 transfer
- M1_wr  input  1  master write strobe
- M1_address  input  8  master write address
- M1_dout  input  32  master write data
- H_sel  input  1  host port select
- H_wr  input  1  host write (1) / read (0)
- H_address  input  8  host register address
- H_din  input  32  host write data
- H_dout  output  32  host read data, registered
- collect_done  output  1  level: full result set held
- r_interrupt  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, count=0, valid[7:0]=0.
  - Flags err/dup/ovf=0.
  - H_dout=0, collect_done=0, r_interrupt=0.
  - Buffer data contents are don't-care.
- Accept condition: M1_req & M1_wr & (BASE_ADDR <= M1_address < BASE_ADDR+NUM_RESULTS).
  - slot = M1_address - BASE_ADDR, taken as 3 bits.
  - Data is written on the same clk edge.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: accepted write -> store, valid[slot]=1, count=1, go COLLECT. If NUM_RESULTS==1, go straight to DONE instead.
  - COLLECT, accepted write to invalid slot: store, set valid, count+1. If count+1==NUM_RESULTS, go DONE.
  - COLLECT, accepted write to valid slot: overwrite data, count unchanged, set dup flag.
  - DONE: collect_done=1. All M1 writes are ignored (data untouched) and set ovf. Remain in DONE until clear.
- r_interrupt is high exactly in the first cycle the registered state is DONE, then low. It does not re-fire without a clear.
- M1 write with M1_req=1, M1_wr=1 outside the window, in any state: ignored, sets err. M1_req=0 or M1_wr=0: no effect.
- Host map, offset = H_address:
  - 8'h00..8'h07: result slot n (read only; writes ignored).
  - 8'h08: status = {20'b0, count[3:0], 1'b0, ovf, dup, err, 3'b0, collect_done}, where count is bits 11:8.
  - 8'h09: control. A write with H_din[0]=1 is a clear.
  - Other addresses: read 0, writes ignored.
- Host read: H_sel & ~H_wr at edge k -> H_dout holds the addressed value after edge k (1-cycle latency). H_dout holds its value when H_sel=0.
  - Reading a slot returns stored data regardless of its valid bit.
  - A read in the same cycle as a write to that slot returns the pre-write value.
- Clear: on the next edge, state=IDLE, count=0, valid=0, err/dup/ovf=0, collect_done=0. Buffer data is retained.
  - Clear in the same cycle as an accepted M1 write: clear wins and the write is dropped entirely.
- count width: 4 bits, saturating at NUM_RESULTS (cannot exceed by construction).
- Reset asserted mid-collection: immediate return to reset values; no interrupt is issued.

Test Plan:
- Reset, then write M1 addrs 8'h20..8'h27 with data 32'h100+i, back-to-back -> collect_done rises after the 8th edge. r_interrupt is a single 1-cycle pulse. Host reads of 8'h00..8'h07 return 32'h100..32'h107 one cycle after each request. Status reads 32'h0000_0801.
- Write 8'h23 twice (32'hAAAA then 32'hBBBB), then the remaining 7 slots -> DONE after 9 writes total. Slot 3 reads 32'hBBBB; status dup bit (bit 5) is set.
- Write M1_address 8'h1F and 8'h28 -> no data change, count stays 0, state stays IDLE, err (bit 4) is set.
- In DONE, write 8'h20 with 32'hDEAD -> slot 0 unchanged, ovf (bit 6) set, no second interrupt. Then host writes 32'h1 to 8'h09 -> status reads 0 and collect_done=0.
- Host clear and accepted M1 write to 8'h21 in the same cycle -> count=0, valid=0, state IDLE; slot 1 data equals its prior value.
- After 4 accepted writes, pulse reset_n low asynchronously between edges -> outputs zero immediately. Re-collecting 8 writes afterwards completes normally with exactly one interrupt.

Source files
------------

// File: rtl/matrix_result_sink.sv
// Result sink for the matrix master's M1 bus: captures result words into an
// 8-deep buffer, tracks arrival, signals completion and exposes a host port.
module matrix_result_sink #(
  parameter logic [7:0]  BASE_ADDR   = 8'h20,
  parameter int unsigned NUM_RESULTS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M1_req,
  input  logic        M1_wr,
  input  logic [7:0]  M1_address,
  input  logic [31:0] M1_dout,
  input  logic        H_sel,
  input  logic        H_wr,
  input  logic [7:0]  H_address,
  input  logic [31:0] H_din,
  output logic [31:0] H_dout,
  output logic        collect_done,
  output logic        r_interrupt
);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  localparam logic [8:0] WinEnd = {1'b0, BASE_ADDR} + 9'(NUM_RESULTS);
  localparam logic [3:0] NumRes = 4'(NUM_RESULTS);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  valid_q, valid_d;
  logic        err_q, err_d;
  logic        dup_q, dup_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        irq_q, irq_d;
  logic [31:0] h_dout_q, h_dout_d;
  logic [31:0] buf_q [8];

  logic        m1_wr_en, in_win, clear, accept, buf_we;
  logic [7:0]  slot_off;
  logic [2:0]  slot;
  logic [3:0]  count_inc;
  logic [31:0] status, rd_data;

  assign m1_wr_en  = M1_req & M1_wr;
  assign in_win    = (M1_address >= BASE_ADDR) && ({1'b0, M1_address} < WinEnd);
  assign slot_off  = M1_address - BASE_ADDR;
  assign slot      = slot_off[2:0];
  assign clear     = H_sel & H_wr & (H_address == 8'h09) & H_din[0];
  // A clear in the same cycle drops the M1 write entirely.
  assign accept    = m1_wr_en & in_win & ~clear;
  assign count_inc = count_q + 4'd1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    dup_d   = dup_q;
    ovf_d   = ovf_q;
    buf_we  = 1'b0;
    if (clear) begin
      state_d = StIdle;
      count_d = 4'd0;
      valid_d = 8'd0;
      err_d   = 1'b0;
      dup_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (m1_wr_en && !in_win) err_d = 1'b1;
      if (m1_wr_en && state_q == StDone) ovf_d = 1'b1;
      if (accept) begin
        unique case (state_q)
          StIdle: begin
            buf_we  = 1'b1;
            valid_d = 8'd1 << slot;
            count_d = 4'd1;
            state_d = (NumRes == 4'd1) ? StDone : StCollect;
          end
          StCollect: begin
            buf_we = 1'b1;
            if (valid_q[slot]) begin
              dup_d = 1'b1;
            end else begin
              valid_d[slot] = 1'b1;
              count_d       = count_inc;
              if (count_inc == NumRes) state_d = StDone;
            end
          end
          StDone: ;
          default: state_d = StIdle;
        endcase
      end
    end
    done_d = (state_d == StDone);
    irq_d  = (state_d == StDone) && (state_q != StDone);
  end

  assign status = {20'd0, count_q, 1'b0, ovf_q, dup_q, err_q, 3'd0, done_q};

  always_comb begin
    rd_data = 32'd0;
    if (H_address[7:3] == 5'd0) rd_data = buf_q[H_address[2:0]];
    else if (H_address == 8'h08) rd_data = status;
    h_dout_d = (H_sel && !H_wr) ? rd_data : h_dout_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= 4'd0;
      valid_q  <= 8'd0;
      err_q    <= 1'b0;
      dup_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      h_dout_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      dup_q    <= dup_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      h_dout_q <= h_dout_d;
    end
  end

  // Buffer contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[slot] <= M1_dout;
  end

  assign H_dout       = h_dout_q;
  assign collect_done = done_q;
  assign r_interrupt  = irq_q;

endmodule

// File: tb/tb_matrix_result_sink.sv
// Directed bench for matrix_result_sink with hand-computed expectations.
module tb_matrix_result_sink;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        M1_req, M1_wr;
  logic [7:0]  M1_address;
  logic [31:0] M1_dout;
  logic        H_sel, H_wr;
  logic [7:0]  H_address;
  logic [31:0] H_din;
  logic [31:0] H_dout;
  logic        collect_done, r_interrupt;

  int vectors = 0;
  int fails   = 0;
  int irq_cnt;

  matrix_result_sink #(.BASE_ADDR(8'h20), .NUM_RESULTS(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .M1_req       (M1_req),
    .M1_wr        (M1_wr),
    .M1_address   (M1_address),
    .M1_dout      (M1_dout),
    .H_sel        (H_sel),
    .H_wr         (H_wr),
    .H_address    (H_address),
    .H_din        (H_din),
    .H_dout       (H_dout),
    .collect_done (collect_done),
    .r_interrupt  (r_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m1(input logic [7:0] a, input logic [31:0] d);
    M1_req = 1'b1; M1_wr = 1'b1; M1_address = a; M1_dout = d;
  endtask

  task automatic m1_idle();
    M1_req = 1'b0; M1_wr = 1'b0; M1_address = 8'h00; M1_dout = 32'h0;
  endtask

  task automatic host_idle();
    H_sel = 1'b0; H_wr = 1'b0; H_address = 8'h00; H_din = 32'h0;
  endtask

  task automatic hread(input logic [7:0] a, input logic [31:0] exp, input string tag);
    H_sel = 1'b1; H_wr = 1'b0; H_address = a;
    cyc();
    host_idle();
    chk(tag, H_dout, exp);
  endtask

  task automatic hclear();
    H_sel = 1'b1; H_wr = 1'b1; H_address = 8'h09; H_din = 32'h1;
    cyc();
    host_idle();
  endtask

  initial begin
    reset_n = 1'b0;
    m1_idle();
    host_idle();
    cyc(); cyc();
    chk("rst_dout", H_dout, 32'h0);
    chk("rst_done", {31'd0, collect_done}, 32'h0);
    chk("rst_irq", {31'd0, r_interrupt}, 32'h0);
    reset_n = 1'b1;
    cyc();

    // Full back-to-back collection.
    irq_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      m1(8'h20 + 8'(i), 32'h100 + i);
      cyc();
      chk($sformatf("fill_done_%0d", i), {31'd0, collect_done}, (i == 7) ? 32'h1 : 32'h0);
      if (r_interrupt) irq_cnt++;
    end
    m1_idle();
    for (int i = 0; i < 8; i++) begin
      H_sel = 1'b1; H_wr = 1'b0; H_address = 8'(i);
      cyc();
      chk($sformatf("fill_slot_%0d", i), H_dout, 32'h100 + i);
      if (r_interrupt) irq_cnt++;
    end
    host_idle();
    chk("fill_irq_count", irq_cnt, 32'd1);
    hread(8'h08, 32'h0000_0801, "fill_status");
    cyc();
    chk("dout_hold", H_dout, 32'h0000_0801);
    hread(8'h0C, 32'h0, "unmapped_read");

    // Writes while DONE are ignored and flag overflow.
    m1(8'h20, 32'hDEAD);
    cyc();
    m1_idle();
    chk("ovf_no_irq", {31'd0, r_interrupt}, 32'h0);
    hread(8'h00, 32'h100, "ovf_slot0");
    hread(8'h08, 32'h0000_0841, "ovf_status");
    hclear();
    chk("clr_done", {31'd0, collect_done}, 32'h0);
    hread(8'h08, 32'h0, "clr_status");

    // Out-of-window writes.
    m1(8'h1F, 32'hBAD0); cyc();
    m1(8'h28, 32'hBAD1); cyc();
    m1_idle();
    hread(8'h08, 32'h0000_0010, "err_status");
    hread(8'h07, 32'h107, "err_slot7");
    hread(8'h00, 32'h100, "err_slot0");
    hclear();

    // Duplicate write to slot 3.
    irq_cnt = 0;
    m1(8'h23, 32'hAAAA); cyc();
    m1(8'h23, 32'hBBBB); cyc();
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        m1(8'h20 + 8'(i), 32'h200 + i);
        cyc();
        if (r_interrupt) irq_cnt++;
        if (i == 6) chk("dup_not_done", {31'd0, collect_done}, 32'h0);
      end
    end
    m1_idle();
    chk("dup_done", {31'd0, collect_done}, 32'h1);
    chk("dup_irq_count", irq_cnt, 32'd1);
    hread(8'h03, 32'hBBBB, "dup_slot3");
    hread(8'h00, 32'h200, "dup_slot0");
    hread(8'h08, 32'h0000_0821, "dup_status");
    hclear();

    // Clear colliding with an accepted write: write dropped.
    m1(8'h20, 32'h300); cyc();
    m1(8'h21, 32'hC0DE);
    H_sel = 1'b1; H_wr = 1'b1; H_address = 8'h09; H_din = 32'h1;
    cyc();
    m1_idle();
    host_idle();
    hread(8'h08, 32'h0, "coll_status");
    hread(8'h01, 32'h201, "coll_slot1");
    hread(8'h00, 32'h300, "coll_slot0");

    // Host writes to slot addresses are ignored.
    H_sel = 1'b1; H_wr = 1'b1; H_address = 8'h02; H_din = 32'hFFFF_FFFF;
    cyc();
    host_idle();
    hread(8'h02, 32'h202, "host_wr_slot2");
    hclear();

    // Async reset mid-collection.
    for (int i = 0; i < 4; i++) begin
      m1(8'h20 + 8'(i), 32'h400 + i);
      cyc();
    end
    m1_idle();
    hread(8'h08, 32'h0000_0400, "mid_status");
    #2 reset_n = 1'b0;
    #1;
    chk("async_dout", H_dout, 32'h0);
    chk("async_done", {31'd0, collect_done}, 32'h0);
    chk("async_irq", {31'd0, r_interrupt}, 32'h0);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_irq", {31'd0, r_interrupt}, 32'h0);

    irq_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      m1(8'h20 + 8'(i), 32'h500 + i);
      cyc();
      if (r_interrupt) irq_cnt++;
      if (i == 3) chk("recol_not_done", {31'd0, collect_done}, 32'h0);
    end
    m1_idle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (r_interrupt) irq_cnt++;
    end
    chk("recol_irq_count", irq_cnt, 32'd1);
    chk("recol_done", {31'd0, collect_done}, 32'h1);
    hread(8'h08, 32'h0000_0801, "recol_status");
    hread(8'h07, 32'h507, "recol_slot7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
